bch_error_locate: RTL and testbench

Consumer of Chien-search output in the BCH decode path. Each cycle it reduces the per-bit Chien term vectors to error flags, XORs them into codeword data read from the external data buffer, and streams out corrected data. At end of codeword it compares the number of roots found against the expected error count (degree of sigma) and flags an uncorrectable word.

---
 rtl/bch_error_locate.sv | 153 +++++++++++++++
 tb/tb_bch_error_locate.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bch_error_locate.sv
// Turns Chien-search term vectors into per-bit error flags, corrects buffered data and
// flags words whose root count disagrees with deg(sigma). Define BCH_ERR_COUNT_EN for err_found.
`ifndef BCH_PARAMS
`define BCH_PARAMS(m, t) (((m) << 8) | (t))
`endif
`ifndef BCH_M
`define BCH_M(p) (((p) >> 8) & 255)
`endif
`ifndef BCH_T
`define BCH_T(p) ((p) & 255)
`endif
`ifndef BCH_SIGMA_SZ
`define BCH_SIGMA_SZ(p) ((`BCH_T(p) + 1) * `BCH_M(p))
`endif
`ifndef BCH_SANE
`define BCH_SANE `BCH_PARAMS(4, 2)
`endif

module bch_error_locate #(
    parameter int P    = `BCH_SANE,
    parameter int BITS = 1,
    localparam int M   = `BCH_M(P),
    localparam int T   = `BCH_T(P),
    localparam int EW  = $clog2(T + 2)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           chien_first,
    input  logic                           chien_last,
    input  logic                           chien_valid,
    input  logic [`BCH_SIGMA_SZ(P)*BITS-1:0] chien,
    input  logic [EW-1:0]                  err_expected,
    output logic                           data_rd,
    input  logic [BITS-1:0]                data_in,
    output logic [BITS-1:0]                data_out,
    output logic                           out_valid,
    output logic                           out_first,
    output logic                           out_last,
    output logic                           out_fail,
    output logic                           overrun
`ifdef BCH_ERR_COUNT_EN
    ,
    output logic [EW-1:0]                  err_found
`endif
);
    typedef enum logic {IDLE, SEARCH} state_t;

    localparam int CW = EW + $clog2(BITS + 1) + 1;
    localparam logic [EW-1:0] CSAT = '1;
    localparam logic [CW-1:0] CMAX = {{(CW - EW){1'b0}}, CSAT};

    state_t            state_q, state_d;
    logic              accept, start, overrun_d;
    logic [BITS-1:0]   err_flags;
    logic [CW-1:0]     pop, base, sum;
    logic [EW-1:0]     count_q, count_d, expected_q, expected_d;
    logic              s1_valid_q, s1_first_q, s1_last_q;
    logic [BITS-1:0]   s1_err_q;
    logic              out_valid_q, out_first_q, out_last_q, out_fail_q, overrun_q;
    logic [BITS-1:0]   data_out_q;

    // A bit position is a root when the Chien terms of that position sum to zero.
    for (genvar gi = 0; gi < BITS; gi++) begin : g_bit
        logic [M-1:0] term_sum;
        always_comb begin
            term_sum = '0;
            for (int i = 0; i <= T; i++) begin
                term_sum = term_sum ^ chien[(gi * (T + 1) + i) * M +: M];
            end
        end
        assign err_flags[gi] = (term_sum == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (chien_valid) begin
            if (chien_first)                         state_d = chien_last ? IDLE : SEARCH;
            else if (state_q == SEARCH && chien_last) state_d = IDLE;
        end
    end

    always_comb begin
        start     = chien_valid && chien_first;
        accept    = chien_valid && (chien_first || state_q == SEARCH);
        overrun_d = start && (state_q == SEARCH);
        data_rd   = accept;
    end

    // A new word (including one that aborts the current word) restarts the root count.
    always_comb begin
        pop = '0;
        for (int b = 0; b < BITS; b++) pop = pop + CW'(err_flags[b]);
        base       = start ? '0 : {{(CW - EW){1'b0}}, count_q};
        sum        = base + pop;
        count_d    = count_q;
        expected_d = expected_q;
        if (accept) begin
            count_d = (sum > CMAX) ? CSAT : sum[EW-1:0];
            if (start) expected_d = err_expected;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q     <= '0;
            expected_q  <= '0;
            s1_valid_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_err_q    <= '0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_fail_q  <= 1'b0;
            overrun_q   <= 1'b0;
            data_out_q  <= '0;
        end else begin
            count_q     <= count_d;
            expected_q  <= expected_d;
            s1_valid_q  <= accept;
            s1_first_q  <= start;
            s1_last_q   <= accept && chien_last;
            s1_err_q    <= accept ? err_flags : '0;
            out_valid_q <= s1_valid_q;
            out_first_q <= s1_valid_q && s1_first_q;
            out_last_q  <= s1_valid_q && s1_last_q;
            out_fail_q  <= s1_valid_q && s1_last_q && (count_q != expected_q);
            overrun_q   <= overrun_d;
            data_out_q  <= s1_valid_q ? (data_in ^ s1_err_q) : '0;
        end
    end

`ifdef BCH_ERR_COUNT_EN
    logic [EW-1:0] err_found_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) err_found_q <= '0;
        else          err_found_q <= (s1_valid_q && s1_last_q) ? count_q : '0;
    end
    assign err_found = err_found_q;
`endif

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;
    assign out_fail  = out_fail_q;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_bch_error_locate.sv
// Bench for bch_error_locate: one BITS=1 and one BITS=4 instance (M=4, T=2) share a directed
// stimulus; a word-level model predicts each output beat, checked every cycle.
module tb_bch_error_locate;
    typedef struct {
        int         due;
        logic [3:0] data;
        bit         first;
        bit         last;
        bit         fail;
        logic [1:0] found;
    } item_t;

    logic        clk, reset_n;
    logic        chien_first, chien_last, chien_valid;
    logic [1:0]  err_expected;
    logic [11:0] chien1;
    logic [47:0] chien4;
    logic [0:0]  data_in1, data_out1;
    logic [3:0]  data_in4, data_out4;
    logic        rd1, ov1, of1, ol1, ofl1, ovr1;
    logic        rd4, ov4, of4, ol4, ofl4, ovr4;
    logic [1:0]  found1, found4;

    bch_error_locate #(.BITS(1)) u_b1 (
        .clk(clk), .reset_n(reset_n), .chien_first(chien_first), .chien_last(chien_last),
        .chien_valid(chien_valid), .chien(chien1), .err_expected(err_expected),
        .data_rd(rd1), .data_in(data_in1), .data_out(data_out1), .out_valid(ov1),
        .out_first(of1), .out_last(ol1), .out_fail(ofl1), .overrun(ovr1)
`ifdef BCH_ERR_COUNT_EN
        , .err_found(found1)
`endif
    );

    bch_error_locate #(.BITS(4)) u_b4 (
        .clk(clk), .reset_n(reset_n), .chien_first(chien_first), .chien_last(chien_last),
        .chien_valid(chien_valid), .chien(chien4), .err_expected(err_expected),
        .data_rd(rd4), .data_in(data_in4), .data_out(data_out4), .out_valid(ov4),
        .out_first(of4), .out_last(ol4), .out_fail(ofl4), .overrun(ovr4)
`ifdef BCH_ERR_COUNT_EN
        , .err_found(found4)
`endif
    );

`ifndef BCH_ERR_COUNT_EN
    assign found1 = 2'd0;
    assign found4 = 2'd0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_fail   = 0;
    int     cyc      = 0;
    bit     exp_rd[0:1023];
    bit     exp_ovr[0:1023];
    item_t  q0[$];
    item_t  q1[$];
    bit     in_word = 0;
    int     cnt[2];
    int     model_cnt_last[2];
    logic   last_fail[2];
    int     n_last[2];
    logic [1:0] exp_e = 0;
    logic [3:0] pend = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [11:0] make_terms(input bit err);
        logic [3:0] a, b, nz;
        a  = 4'($urandom_range(0, 15));
        b  = 4'($urandom_range(0, 15));
        nz = 4'($urandom_range(1, 15));
        return {(err ? (a ^ b) : (a ^ b ^ nz)), b, a};
    endfunction

    // One input cycle: drive both DUTs and record what the model says must come out.
    task automatic beat(input bit v, input bit f, input bit l, input logic [3:0] em,
                        input logic [3:0] dat, input logic [1:0] ee);
        bit    acc;
        item_t it;
        int    pc;
        logic [11:0] tm;
        chien_valid = v; chien_first = f; chien_last = l; err_expected = ee;
        for (int b = 0; b < 4; b++) begin
            tm = make_terms(em[b]);
            chien4[b*12 +: 12] = tm;
            if (b == 0) chien1 = tm;
        end
        data_in1 = pend[0:0];
        data_in4 = pend;
        pend     = dat;
        acc = v && (f || in_word);
        exp_rd[cyc] = acc;
        if (v && f && in_word) exp_ovr[cyc + 1] = 1'b1;
        if (acc) begin
            if (f) exp_e = ee;
            for (int d = 0; d < 2; d++) begin
                pc = (d == 0) ? int'(em[0]) : $countones(em);
                cnt[d] = (f ? 0 : cnt[d]) + pc;
                if (cnt[d] > 3) cnt[d] = 3;
                it.due   = cyc + 2;
                it.first = f;
                it.last  = l;
                it.data  = (d == 0) ? {3'b000, dat[0] ^ em[0]} : (dat ^ em);
                it.fail  = l && (cnt[d] != int'(exp_e));
                it.found = l ? 2'(cnt[d]) : 2'd0;
                if (l) model_cnt_last[d] = cnt[d];
                if (d == 0) q0.push_back(it);
                else        q1.push_back(it);
            end
        end
        if (v) begin
            if (f)      in_word = !l;
            else if (l) in_word = 0;
        end
        @(posedge clk); #1; cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) beat(0, 0, 0, 4'h0, 4'h0, 2'd0);
    endtask

    task automatic word(input int len, input logic [1:0] ee, input int pa, input logic [3:0] ma,
                        input int pb, input logic [3:0] mb, input int bubble_at, input bit ones);
        logic [3:0] m;
        for (int i = 0; i < len; i++) begin
            if (i == bubble_at) beat(0, 0, 0, 4'hF, 4'h0, 2'd0);
            m = ((i == pa) ? ma : 4'h0) | ((i == pb) ? mb : 4'h0);
            beat(1, i == 0, i == len - 1, m, ones ? 4'hF : 4'($urandom_range(0, 15)), ee);
        end
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        while (q0.size() > 0 && q0[q0.size()-1].due >= cyc) void'(q0.pop_back());
        while (q1.size() > 0 && q1[q1.size()-1].due >= cyc) void'(q1.pop_back());
        for (int k = cyc; k < cyc + 4; k++) exp_ovr[k] = 1'b0;
        in_word = 0;
        idle(n);
        reset_n = 1'b1;
    endtask

    task automatic check_dut(input int d, input logic rd, input logic ovr, input logic ov,
                             input logic of, input logic ol, input logic ofl,
                             input logic [3:0] dout, input logic [1:0] fnd);
        string nm;
        item_t it;
        bit    have;
        nm   = (d == 0) ? "b1" : "b4";
        have = 0;
        if (!reset_n) begin
            chk({nm, ".reset_outs"}, {22'd0, rd, ovr, ov, of, ol, ofl, dout, fnd}, 32'd0);
            return;
        end
        chk({nm, ".data_rd"}, {31'd0, rd}, {31'd0, exp_rd[cyc]});
        chk({nm, ".overrun"}, {31'd0, ovr}, {31'd0, exp_ovr[cyc]});
        if (d == 0) begin
            while (q0.size() > 0 && q0[0].due < cyc) begin
                n_checks++; n_fail++;
                $display("FAIL %s.missing cycle %0d: beat due %0d never seen", nm, cyc, q0[0].due);
                void'(q0.pop_front());
            end
            if (q0.size() > 0 && q0[0].due == cyc) begin it = q0.pop_front(); have = 1; end
        end else begin
            while (q1.size() > 0 && q1[0].due < cyc) begin
                n_checks++; n_fail++;
                $display("FAIL %s.missing cycle %0d: beat due %0d never seen", nm, cyc, q1[0].due);
                void'(q1.pop_front());
            end
            if (q1.size() > 0 && q1[0].due == cyc) begin it = q1.pop_front(); have = 1; end
        end
        if (ol) begin
            n_last[d]++;
            last_fail[d] = ofl;
        end
        if (have) begin
            chk({nm, ".out_valid"}, {31'd0, ov}, 32'd1);
            chk({nm, ".out_first"}, {31'd0, of}, {31'd0, it.first});
            chk({nm, ".out_last"}, {31'd0, ol}, {31'd0, it.last});
            chk({nm, ".data_out"}, {28'd0, dout}, {28'd0, it.data});
            chk({nm, ".out_fail"}, {31'd0, ofl}, {31'd0, it.fail});
`ifdef BCH_ERR_COUNT_EN
            chk({nm, ".err_found"}, {30'd0, fnd}, {30'd0, it.found});
`endif
        end else begin
            chk({nm, ".idle_outs"}, {28'd0, ov, ol, ofl, 1'b0}, 32'd0);
        end
    endtask

    always @(negedge clk) begin
        check_dut(0, rd1, ovr1, ov1, of1, ol1, ofl1, {3'b000, data_out1}, found1);
        check_dut(1, rd4, ovr4, ov4, of4, ol4, ofl4, data_out4, found4);
    end

    task automatic pin(input string nm, input int fb1, input int cb1, input int fb4, input int cb4);
        chk({nm, ".b1.fail"}, {31'd0, last_fail[0]}, fb1);
        chk({nm, ".b1.count"}, model_cnt_last[0], cb1);
        chk({nm, ".b4.fail"}, {31'd0, last_fail[1]}, fb4);
        chk({nm, ".b4.count"}, model_cnt_last[1], cb4);
        last_fail[0] = 1'bx;
        last_fail[1] = 1'bx;
    endtask

    initial begin
        reset_n = 1'b0;
        chien_valid = 0; chien_first = 0; chien_last = 0; err_expected = 0;
        chien1 = 0; chien4 = 0; data_in1 = 0; data_in4 = 0;
        cnt[0] = 0; cnt[1] = 0; n_last[0] = 0; n_last[1] = 0;
        last_fail[0] = 1'bx; last_fail[1] = 1'bx;
        idle(3);
        reset_n = 1'b1;
        idle(2);

        word(8, 2'd0, -1, 4'h0, -1, 4'h0, -1, 1);          // clean word, all-ones data
        idle(3); pin("clean", 0, 0, 0, 0);
        word(8, 2'd1, 3, 4'h1, -1, 4'h0, -1, 1);           // single root at cycle 3
        idle(3); pin("one_root", 0, 1, 0, 1);
        word(8, 2'd1, 2, 4'h1, 5, 4'h1, -1, 0);            // two roots, one expected
        idle(3); pin("two_roots", 1, 2, 1, 2);
        word(8, 2'd3, 2, 4'hF, 5, 4'hF, -1, 0);            // saturation on the wide instance
        idle(3); pin("saturate", 1, 2, 0, 3);

        beat(1, 0, 0, 4'hF, 4'h5, 2'd0);                   // stray beats while idle
        beat(1, 0, 1, 4'hF, 4'h5, 2'd0);
        word(8, 2'd1, 2, 4'h3, -1, 4'h0, -1, 0);           // back-to-back pair
        word(8, 2'd2, 1, 4'h1, 6, 4'h1, 4, 0);
        idle(3); pin("b2b_second", 0, 2, 0, 2);

        beat(1, 1, 1, 4'h1, 4'hA, 2'd1);                   // one-cycle word
        idle(3); pin("single", 0, 1, 0, 1);

        for (int i = 0; i < 4; i++) beat(1, i == 0, 0, (i == 1) ? 4'hF : 4'h0, 4'h6, 2'd3);
        word(8, 2'd0, -1, 4'h0, -1, 4'h0, -1, 0);          // restarts mid-word
        idle(3); pin("after_overrun", 0, 0, 0, 0);

        for (int i = 0; i < 5; i++) beat(1, i == 0, 0, (i == 2) ? 4'h1 : 4'h0, 4'h9, 2'd1);
        do_reset(2);
        idle(2);
        word(8, 2'd1, 4, 4'h1, -1, 4'h0, -1, 0);
        idle(4); pin("after_reset", 0, 1, 0, 1);

        chk("b1.leftover", q0.size(), 0);
        chk("b4.leftover", q1.size(), 0);
        chk("b1.words_done", n_last[0], 9);
        chk("b4.words_done", n_last[1], 9);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
